// File: rtl/bl_mux_scheduler.sv
// bl_mux_scheduler
//   Round-robin owner sequencer for the shared 8-way bitline mux. It hands the
//   mux to one of NUM_REQ requesters at a time, latches the owner's bitline
//   address at grant, waits SETTLE_CYCLES before reporting sel_ready, and
//   inserts one dead cycle (mux_en low, RELEASE) between successive owners.
//
//   Optional build macro BL_MUX_TIMEOUT_EN: an owner holding ACTIVE for
//   TIMEOUT_CYCLES cycles is forcibly released (timeout_flag pulses during the
//   RELEASE cycle) and masked from arbitration until it drops req.
//
// Ports
//   Clk           rising-edge clock
//   Reset         asynchronous, active-high reset
//   req           per-requester request, held for the whole access
//   req_addr      packed 3-bit addresses, requester i at [3i+2:3i]
//   grant         one-hot owner, zero when there is no owner
//   sel_ready     owner's bitline has settled
//   mux_en        bitline mux enable
//   mux_a         bitline mux address (0 whenever mux_en is 0)
//   busy          scheduler is not idle
//   timeout_flag  one-cycle pulse on forced release (0 without the macro)
module bl_mux_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 sel_ready,
    output logic                 mux_en,
    output logic [2:0]           mux_a,
    output logic                 busy,
    output logic                 timeout_flag
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8 || SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("bl_mux_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, RELEASE} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   owner, owner_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [3:0]         cnt, cnt_n;
    logic [NUM_REQ-1:0] grant_n;
    logic               sel_ready_n, mux_en_n, busy_n;
    logic [2:0]         mux_a_n;
    logic               do_release;

    logic [NUM_REQ-1:0] elig;
    logic               win_vld;
    logic [PTR_W-1:0]   win;

`ifdef BL_MUX_TIMEOUT_EN
    localparam int ACT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [ACT_W-1:0]   act_cnt, act_cnt_n;
    logic [NUM_REQ-1:0] to_mask, to_mask_n;
    logic               timeout_flag_n;

    assign elig = req & ~to_mask;
`else
    assign elig = req;
`endif

    // Rotating priority scan starting at rr_ptr.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win     = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        cnt_n       = cnt;
        grant_n     = grant;
        sel_ready_n = sel_ready;
        mux_en_n    = mux_en;
        mux_a_n     = mux_a;
        busy_n      = busy;
        do_release  = 1'b0;
`ifdef BL_MUX_TIMEOUT_EN
        act_cnt_n      = act_cnt;
        // A masked requester is unmasked once it is seen with req low.
        to_mask_n      = to_mask & req;
        timeout_flag_n = 1'b0;
`endif
        case (state)
            IDLE, RELEASE: begin
                if (win_vld) begin
                    owner_n       = win;
                    grant_n       = '0;
                    grant_n[win]  = 1'b1;
                    mux_en_n      = 1'b1;
                    mux_a_n       = req_addr[3*int'(win) +: 3];
                    busy_n        = 1'b1;
`ifdef BL_MUX_TIMEOUT_EN
                    act_cnt_n     = '0;
`endif
                    if (SETTLE_CYCLES == 0) begin
                        state_n     = ACTIVE;
                        sel_ready_n = 1'b1;
                    end else begin
                        state_n     = SETTLE;
                        cnt_n       = 4'(SETTLE_CYCLES);
                        sel_ready_n = 1'b0;
                    end
                end else begin
                    state_n     = IDLE;
                    grant_n     = '0;
                    mux_en_n    = 1'b0;
                    mux_a_n     = '0;
                    sel_ready_n = 1'b0;
                    busy_n      = 1'b0;
                end
            end
            SETTLE: begin
                if (!req[owner]) begin
                    do_release = 1'b1;
                end else if (cnt <= 4'd1) begin
                    state_n     = ACTIVE;
                    sel_ready_n = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ACTIVE: begin
                if (!req[owner]) begin
                    do_release = 1'b1;
                end
`ifdef BL_MUX_TIMEOUT_EN
                else if (act_cnt == ACT_W'(TIMEOUT_CYCLES - 1)) begin
                    do_release       = 1'b1;
                    timeout_flag_n   = 1'b1;
                    to_mask_n[owner] = 1'b1;
                end else begin
                    act_cnt_n = act_cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        // Break-before-make: one cycle with everything low before re-arbitrating.
        if (do_release) begin
            state_n     = RELEASE;
            grant_n     = '0;
            mux_en_n    = 1'b0;
            mux_a_n     = '0;
            sel_ready_n = 1'b0;
            busy_n      = 1'b1;
            rr_ptr_n    = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            grant     <= '0;
            sel_ready <= 1'b0;
            mux_en    <= 1'b0;
            mux_a     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            cnt       <= cnt_n;
            grant     <= grant_n;
            sel_ready <= sel_ready_n;
            mux_en    <= mux_en_n;
            mux_a     <= mux_a_n;
            busy      <= busy_n;
        end
    end

`ifdef BL_MUX_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            act_cnt      <= '0;
            to_mask      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            act_cnt      <= act_cnt_n;
            to_mask      <= to_mask_n;
            timeout_flag <= timeout_flag_n;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_bl_mux_scheduler.sv
module tb_bl_mux_scheduler;
    localparam int NR     = 4;
    localparam int SETTLE = 2;
    localparam int TO     = 8;
`ifdef BL_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            Clk;
    logic            Reset;
    logic [NR-1:0]   req;
    logic [3*NR-1:0] req_addr;
    logic [NR-1:0]   grant;
    logic            sel_ready, mux_en, busy, timeout_flag;
    logic [2:0]      mux_a;

    bl_mux_scheduler #(.NUM_REQ(NR), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .grant(grant),
        .sel_ready(sel_ready), .mux_en(mux_en), .mux_a(mux_a), .busy(busy),
        .timeout_flag(timeout_flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic          sel_ready;
        logic          mux_en;
        logic [2:0]    mux_a;
        logic          busy;
        logic          tflag;
    } obs_t;

    obs_t exp_q[$];
    int   order_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: who owns the mux, for how long, and whether this is
    // the dead cycle after a release.
    int            m_owner;
    int            m_age;
    bit            m_rel;
    int            m_rr;
    logic [2:0]    m_addr;
    logic [NR-1:0] m_mask;
    bit            m_tflag;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_rel = 0; m_rr = 0; m_addr = '0; m_mask = '0; m_tflag = 0;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        if (m_owner >= 0) begin
            o.grant[m_owner] = 1'b1;
            o.mux_en         = 1'b1;
            o.mux_a          = m_addr;
            o.sel_ready      = (m_age >= SETTLE);
        end
        o.busy  = (m_owner >= 0) || m_rel;
        o.tflag = m_tflag;
        return o;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step(input logic [NR-1:0] r, input logic [3*NR-1:0] a);
        logic [NR-1:0] nmask;
        logic [NR-1:0] elig;
        int w;
        nmask   = m_mask & r;
        m_tflag = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || (TO_EN && m_age >= SETTLE && (m_age - SETTLE + 1) >= TO)) begin
                if (r[m_owner]) begin
                    m_tflag         = 1;
                    nmask[m_owner]  = 1'b1;
                end
                m_rr    = (m_owner + 1) % NR;
                m_owner = -1;
                m_rel   = 1;
            end else begin
                m_age++;
            end
        end else begin
            m_rel = 0;
            elig  = r & ~m_mask;
            w     = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && elig[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
                m_addr  = a[w*3 +: 3];
                order_q.push_back(w);
            end
        end
        m_mask = nmask;
        exp_q.push_back(model_out());
    endtask

    // One cycle: drive inputs, let the edge happen, predict, move off the edge.
    task automatic step(input logic [NR-1:0] r, input logic [3*NR-1:0] a);
        req      = r;
        req_addr = a;
        @(posedge Clk);
        model_step(r, a);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        req   = '0;
        exp_q.delete();
        model_reset();
        #1;
        check_val("async_reset_outputs",
                  int'({grant, sel_ready, mux_en, mux_a, busy, timeout_flag}), 0);
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;
    endtask

    // Monitor: every predicted cycle is compared at the falling edge.
    initial begin
        obs_t e, g;
        forever begin
            @(negedge Clk);
            if (!Reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{grant, sel_ready, mux_en, mux_a, busy, timeout_flag};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL cycle_out t=%0t: got gnt=%b rdy=%b en=%b a=%0d busy=%b to=%b expected gnt=%b rdy=%b en=%b a=%0d busy=%b to=%b",
                             $time, g.grant, g.sel_ready, g.mux_en, g.mux_a, g.busy, g.tflag,
                             e.grant, e.sel_ready, e.mux_en, e.mux_a, e.busy, e.tflag);
                end
            end
        end
    end

    function automatic logic [3*NR-1:0] rand_addr();
        return (3*NR)'($urandom);
    endfunction

    initial begin
        logic [NR-1:0]   r;
        logic [3*NR-1:0] a;
        Reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        model_reset();
        do_reset();

        // Single requester 1 at address 5.
        repeat (3) step('0, rand_addr());
        a = rand_addr(); a[5:3] = 3'd5;
        step(4'b0010, a);
        check_val("first_grant", int'(grant), 2);
        check_val("first_mux_a", int'(mux_a), 5);
        repeat (6) step(4'b0010, a);
        step('0, a);
        step('0, a);

        // Round-robin order with everyone requesting.
        do_reset();
        order_q.delete();
        for (int c = 0; c < 42; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_age >= SETTLE + 4) r[m_owner] = 1'b0;
            step(r, rand_addr());
        end
        check_val("rr_count", order_q.size() >= 5 ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < order_q.size(); i++)
            check_val("rr_order", order_q[i], i % NR);
        repeat (3) step('0, rand_addr());

        // Requester 2 aborts during SETTLE; requester 3 must win next.
        step(4'b0100, rand_addr());
        step(4'b0000, rand_addr());
        check_val("abort_release_en", int'(mux_en), 0);
        step(4'b1111, rand_addr());
        check_val("after_abort_grant", int'(grant), 8);
        repeat (3) step(4'b1000, rand_addr());
        repeat (2) step('0, rand_addr());

        // Owner address changes after grant are ignored.
        a = rand_addr(); a[5:3] = 3'd5;
        step(4'b0010, a);
        for (int c = 0; c < 5; c++) begin
            a = rand_addr(); a[5:3] = 3'd1;
            step(4'b0010, a);
        end
        check_val("addr_latched", int'(mux_a), 5);

        // Reset mid-ACTIVE, then a fresh request from requester 0.
        repeat (5) step(4'b0001, rand_addr());
        do_reset();
        step(4'b0001, rand_addr());
        check_val("post_reset_grant", int'(grant), 1);
        repeat (3) step('0, rand_addr());

        // Long hold by a single requester (forced release only with timeout).
        repeat (30) step(4'b0001, rand_addr());
        repeat (2) step('0, rand_addr());
        repeat (5) step(4'b0001, rand_addr());
        repeat (2) step('0, rand_addr());

        // Randomized traffic: requests toggle occasionally, addresses churn.
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(7) == 0) r[i] = ~r[i];
            step(r, rand_addr());
        end

        @(negedge Clk);
        #1;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
